// File: rtl/prbs_tx_gen_pkg.sv
// prbs_tx_gen_pkg: PRBS9 constants, FSM encoding and LFSR step helper
package prbs_tx_gen_pkg;
  localparam int PRBS_LEN = 511;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;
  localparam logic [8:0] DEF_SEED = 9'h1AA;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;
  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction
endpackage

// File: rtl/prbs_tx_gen_lfsr.sv
// lfsr_prbs9: PRBS9 shift register with parallel load and step enable
module lfsr_prbs9
  import prbs_tx_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [8:0] seed,
  input  logic       step,
  output logic       msb
);
  logic [8:0] s;
  // load wins over step so a restart always begins from the seed
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else if (load) s <= seed;
    else if (step) s <= prbs9_next(s);
  assign msb = s[TAP_HI];
endmodule

// File: rtl/prbs_tx_gen.sv
// prbs_tx_gen: PRBS9 bit generator with sync marker and periodic error injection
module prbs_tx_gen
  import prbs_tx_gen_pkg::*;
#(
  parameter logic [8:0] SEED = DEF_SEED,
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_seed_load,
  input  logic [8:0]      i_seed,
  input  logic [ERRW-1:0] i_err_period,
  output logic            o_bit,
  output logic            o_valid,
  output logic            o_sync,
  output logic            o_inj,
  output logic            o_running,
  output logic [31:0]     o_inj_count
);
  localparam logic [8:0] PCNT_LAST = 9'(PRBS_LEN - 1);
  state_t state, state_n;
  logic [8:0] seed_r, pcnt;
  logic [ERRW-1:0] per_r, icnt;
  logic go, fire, inj, msb;
  assign go = state == IDLE && i_start && !i_stop;
  assign fire = state != IDLE && enable && !i_stop;
  assign inj = per_r != '0 && icnt == per_r - ERRW'(1);
  assign o_running = state == RUN;
  lfsr_prbs9 u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(go),
    .seed(seed_r),
    .step(fire),
    .msb (msb)
  );
  // next state: stop always wins over start and enable
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = go ? ARM : IDLE;
    else if (i_stop) state_n = IDLE;
    else if (state == ARM) state_n = enable ? RUN : ARM;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // seed, counters, injection and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_r <= SEED;
      pcnt <= '0;
      per_r <= '0;
      icnt <= '0;
      o_bit <= 1'b0;
      o_valid <= 1'b0;
      o_sync <= 1'b0;
      o_inj <= 1'b0;
      o_inj_count <= '0;
    end else begin
      if (state == IDLE && i_seed_load) seed_r <= i_seed == '0 ? SEED : i_seed;
      o_valid <= fire;
      o_sync <= fire && pcnt == '0;
      o_inj <= fire && inj;
      if (go) begin
        pcnt <= '0;
        icnt <= '0;
        per_r <= i_err_period;
        o_inj_count <= '0;
      end else if (fire) begin
        o_bit <= msb ^ inj;
        pcnt <= pcnt == PCNT_LAST ? '0 : pcnt + 9'd1;
        icnt <= per_r == '0 ? icnt : inj ? '0 : icnt + ERRW'(1);
        if (inj && o_inj_count != '1) o_inj_count <= o_inj_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_prbs_tx_gen.sv
// tb_prbs_tx_gen: directed table and sequence checks for prbs_tx_gen
module tb_prbs_tx_gen;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_seed_load = 1'b0;
  logic [8:0] i_seed = '0;
  logic [15:0] i_err_period = '0;
  logic o_bit, o_valid, o_sync, o_inj, o_running;
  logic [31:0] o_inj_count;
  int checks = 0, passes = 0;

  prbs_tx_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .i_start(i_start), .i_stop(i_stop),
    .i_seed_load(i_seed_load), .i_seed(i_seed), .i_err_period(i_err_period),
    .o_bit(o_bit), .o_valid(o_valid), .o_sync(o_sync), .o_inj(o_inj),
    .o_running(o_running), .o_inj_count(o_inj_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  seed;
    logic [15:0] period;
    logic [8:0]  bits;
    logic [31:0] injs;
  } vec_t;
  vec_t vecs[6];
  logic ref_bits[1022];

  function automatic logic [8:0] nx(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic load_seed(input logic [8:0] s);
    i_seed = s; i_seed_load = 1'b1; tick(); i_seed_load = 1'b0;
  endtask

  task automatic start(input logic [15:0] p);
    i_err_period = p; i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic stop();
    enable = 1'b0; i_stop = 1'b1; tick(); i_stop = 1'b0;
  endtask

  initial begin
    logic [8:0] s, v;
    int nvalid, nbad, nsync, ninj;
    logic held;
    s = 9'h001;
    for (int i = 0; i < 1022; i++) begin
      ref_bits[i] = s[8];
      s = nx(s);
    end
    vecs[0] = '{9'h1AA, 16'd0, 9'b110101010, 32'd0};
    vecs[1] = '{9'h000, 16'd0, 9'b110101010, 32'd0};
    vecs[2] = '{9'h001, 16'd0, 9'b000000001, 32'd0};
    vecs[3] = '{9'h1FF, 16'd0, 9'b111111111, 32'd0};
    vecs[4] = '{9'h1AA, 16'd1, 9'b001010101, 32'd9};
    vecs[5] = '{9'h001, 16'd3, 9'b001001000, 32'd3};

    do_reset();
    chk("reset_outs", {27'd0, o_bit, o_valid, o_sync, o_inj, o_running}, 32'd0);
    chk("reset_inj_count", o_inj_count, 32'd0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      load_seed(vecs[k].seed);
      start(vecs[k].period);
      chk($sformatf("arm_not_running_%0d", k), {31'd0, o_running}, 32'd0);
      v = '0;
      nvalid = 0;
      enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
        tick();
        v = {v[7:0], o_bit};
        nvalid += int'(o_valid);
      end
      enable = 1'b0;
      chk($sformatf("vec_bits_%0d", k), {23'd0, v}, {23'd0, vecs[k].bits});
      chk($sformatf("vec_valid_%0d", k), nvalid, 9);
      chk($sformatf("vec_inj_count_%0d", k), o_inj_count, vecs[k].injs);
    end

    // full period with no injection, plus ARM hold
    do_reset();
    load_seed(9'h001);
    start(16'd0);
    tick(); tick();
    chk("arm_hold_valid", {30'd0, o_valid, o_running}, 32'd0);
    nvalid = 0; nbad = 0; nsync = 0; ninj = 0;
    enable = 1'b1;
    for (int i = 0; i < 1022; i++) begin
      tick();
      nvalid += int'(o_valid);
      ninj += int'(o_inj);
      if (o_bit !== ref_bits[i]) nbad++;
      if (i < 511 && ref_bits[i] !== ref_bits[i + 511]) nbad++;
      if (o_sync) begin
        nsync++;
        if (i != 0 && i != 511) nbad++;
      end
    end
    enable = 1'b0;
    chk("p0_running", {31'd0, o_running}, 32'd1);
    chk("p0_valid", nvalid, 1022);
    chk("p0_bits_and_sync_pos", nbad, 0);
    chk("p0_sync_count", nsync, 2);
    chk("p0_inj", ninj, 0);
    stop();
    chk("stop_idle", {31'd0, o_running}, 32'd0);

    // P=100 injection; seed load and period change during RUN ignored
    load_seed(9'h001);
    start(16'd100);
    nbad = 0; ninj = 0;
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i == 50) begin i_seed_load = 1'b1; i_seed = 9'h1FF; i_err_period = 16'd7; end
      tick();
      i_seed_load = 1'b0;
      ninj += int'(o_inj);
      if (o_inj !== ((i + 1) % 100 == 0)) nbad++;
      if (o_bit !== (ref_bits[i] ^ ((i + 1) % 100 == 0))) nbad++;
    end
    chk("p100_pattern", nbad, 0);
    chk("p100_inj", ninj, 5);
    stop();
    chk("p100_count_in_idle", o_inj_count, 32'd5);
    start(16'd0);
    chk("count_clear_on_start", o_inj_count, 32'd0);
    v = '0;
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin tick(); v = {v[7:0], o_bit}; end
    chk("seed_load_ignored_in_run", {23'd0, v}, 32'h001);
    stop();

    // start and stop together in IDLE
    do_reset();
    i_start = 1'b1; i_stop = 1'b1; tick(); i_start = 1'b0; i_stop = 1'b0;
    nvalid = 0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvalid += int'(o_valid) + int'(o_running);
    end
    enable = 1'b0;
    chk("start_stop_idle", nvalid, 0);

    // start and stop together in RUN
    load_seed(9'h001);
    start(16'd0);
    enable = 1'b1; tick();
    i_start = 1'b1; i_stop = 1'b1; tick(); i_start = 1'b0; i_stop = 1'b0;
    enable = 1'b0;
    chk("start_stop_run", {30'd0, o_running, o_valid}, 32'd0);

    // reset mid-RUN at bit 300, then restart
    do_reset();
    load_seed(9'h001);
    start(16'd1);
    enable = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("pre_rst_count", o_inj_count, 32'd300);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_outs", {27'd0, o_bit, o_valid, o_sync, o_inj, o_running}, 32'd0);
    chk("rst_mid_count", o_inj_count, 32'd0);
    enable = 1'b0;
    load_seed(9'h001);
    start(16'd0);
    enable = 1'b1;
    tick();
    chk("restart_sync", {30'd0, o_sync, o_valid}, 32'd3);
    v = {8'd0, o_bit};
    for (int i = 1; i < 9; i++) begin tick(); v = {v[7:0], o_bit}; end
    chk("restart_bits", {23'd0, v}, 32'h001);

    // enable 1-0-0-1 in RUN; bits 8,9 of seed 001 are 1 and 0
    enable = 1'b0;
    tick();
    chk("gap_pre", {30'd0, o_bit, o_valid}, 32'd2);
    nvalid = 0;
    held = 1'b1;
    enable = 1'b1; tick(); nvalid += int'(o_valid);
    chk("gap_bit9", {31'd0, o_bit}, {31'd0, ref_bits[9]});
    enable = 1'b0; tick(); nvalid += int'(o_valid); held &= (o_bit === ref_bits[9]);
    tick(); nvalid += int'(o_valid); held &= (o_bit === ref_bits[9]);
    enable = 1'b1; tick(); nvalid += int'(o_valid);
    enable = 1'b0;
    chk("gap_valid", nvalid, 2);
    chk("gap_held", {31'd0, held}, 32'd1);
    chk("gap_bit10", {31'd0, o_bit}, {31'd0, ref_bits[10]});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
